// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared state encoding, wait-state limit and address-slicing helpers for the APB register bank
package apb_slave_pkg;
  typedef enum logic {IDLE, ACCESS} state_e;
  localparam int MAX_WAIT = 15;
  function automatic int lsb_w(input int dw);
    return $clog2(dw / 8);
  endfunction
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/apb_slave_decode.sv
// apb_slave_decode: combinational word index and error decode of an APB byte address
//   paddr_i  byte address
//   idx_o    word index into the register bank
//   err_o    misaligned or out-of-range address
module apb_slave_decode
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  output logic [idx_w(DEPTH)-1:0]   idx_o,
  output logic                      err_o
);
  localparam int LSB = lsb_w(DATA_WIDTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH * (DATA_WIDTH / 8));
  always_comb begin
    idx_o = paddr_i[LSB +: idx_w(DEPTH)];
    err_o = |(paddr_i & ADDR_WIDTH'(DATA_WIDTH / 8 - 1)) || 64'(paddr_i) >= LIMIT;
  end
endmodule

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB slave with a flop register bank, programmable wait states and PSLVERR decode
//   pclk, rst_n (sync, active low)          clock and reset
//   psel, penable, pwrite, paddr, pwdata    APB request
//   pstrb                                   byte-lane write strobes, only with APB_SLAVE_PSTRB_EN
//   prdata, pready, pslaverr                APB response
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslaverr
);
  localparam int IW = idx_w(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d, dec_err, done;
  logic [IW-1:0] idx_q, idx_d, dec_idx;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d, wdata;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  apb_slave_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_decode (
    .paddr_i(paddr),
    .idx_o(dec_idx),
    .err_o(dec_err)
  );
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      prdata_q <= prdata_d;
      if (done && wr_q && !err_q) mem_q[idx_q] <= wdata;
    end
  end
  // read data is captured at setup so it is stable for the whole access phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    idx_d    = idx_q;
    prdata_d = prdata_q;
    if (state_q == IDLE) begin
      if (psel && !penable) begin
        state_d = ACCESS;
        cnt_d   = CW'(WAIT_STATES);
        wr_d    = pwrite;
        err_d   = dec_err;
        idx_d   = dec_idx;
        if (!pwrite) prdata_d = dec_err ? '0 : mem_q[dec_idx];
      end
    end else if (!psel) state_d = IDLE;
    else if (penable && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    else if (penable) state_d = IDLE;
  end
  always_comb begin
    done     = state_q == ACCESS && psel && penable && cnt_q == '0;
    pready   = done;
    pslaverr = done && err_q;
    prdata   = prdata_q;
  end
`ifdef APB_SLAVE_PSTRB_EN
  always_comb begin
    wdata = mem_q[idx_q];
    for (int b = 0; b < DATA_WIDTH / 8; b++) if (pstrb[b]) wdata[8*b +: 8] = pwdata[8*b +: 8];
  end
`else
  always_comb wdata = pwdata;
`endif
endmodule
